// File: rtl/sme_record_feeder.sv
// rtl/sme_record_feeder.sv - buffers host byte records and replays them into SME, returning pattern results
// Strings are staged and replayed; each pattern is replayed and followed by a wait for the SME result.
module sme_record_feeder #(
  parameter int STR_MAX = 32,
  parameter int PAT_MAX = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_type,
  input  logic       in_last,
  output logic [7:0] chardata,
  output logic       isstring,
  output logic       ispattern,
  input  logic       sme_valid,
  input  logic       sme_match,
  input  logic [4:0] sme_index,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       res_match,
  output logic [4:0] res_index,
  output logic       res_timeout,
  output logic [1:0] err
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [5:0] STR_LIM = 6'(STR_MAX);
  localparam logic [5:0] PAT_LIM = 6'(PAT_MAX);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_LOAD, S_SEND, S_WAIT, S_RESULT} state_t;

  state_t        state, state_nx;
  logic [7:0]    mem [0:31];
  logic [5:0]    wr_ptr, rd_ptr, len;
  logic          have_str, first, cur_type;
  logic [TW-1:0] timer;

  logic       hs, rec_type, fits, discard, send_done, wait_done;
  logic [5:0] limit;

  assign in_ready  = (state == S_LOAD);
  assign hs        = in_valid && in_ready;
  // Type comes from the first byte of a record; later bytes reuse the latched value.
  assign rec_type  = first ? in_type : cur_type;
  assign limit     = rec_type ? PAT_LIM : STR_LIM;
  assign fits      = (wr_ptr < limit);
  assign discard   = rec_type && !have_str;
  assign send_done = (rd_ptr == len);
  assign wait_done = sme_valid || (timer == TIMER_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_LOAD;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_LOAD:   if (hs && in_last && !discard) state_nx = S_SEND;
      S_SEND:   if (send_done) state_nx = cur_type ? S_WAIT : S_LOAD;
      S_WAIT:   if (wait_done) state_nx = S_RESULT;
      S_RESULT: if (res_ready) state_nx = S_LOAD;
      default:  state_nx = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (hs && fits) mem[wr_ptr[4:0]] <= in_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      len         <= '0;
      have_str    <= 1'b0;
      first       <= 1'b1;
      cur_type    <= 1'b0;
      timer       <= '0;
      chardata    <= '0;
      isstring    <= 1'b0;
      ispattern   <= 1'b0;
      res_valid   <= 1'b0;
      res_match   <= 1'b0;
      res_index   <= '0;
      res_timeout <= 1'b0;
      err         <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          if (hs) begin
            cur_type <= rec_type;
            first    <= in_last;
            if (fits) wr_ptr <= wr_ptr + 6'd1;
            else      err[0] <= 1'b1;
            if (in_last) begin
              wr_ptr <= '0;
              if (discard) begin
                err[1] <= 1'b1;
              end else begin
                // First char goes out on the cycle after the last handshake; a one-byte
                // record has not reached the buffer yet, so take it straight from the bus.
                len       <= fits ? wr_ptr + 6'd1 : wr_ptr;
                rd_ptr    <= 6'd1;
                chardata  <= (wr_ptr == 6'd0) ? in_data : mem[0];
                isstring  <= !rec_type;
                ispattern <= rec_type;
              end
            end
          end
        end
        S_SEND: begin
          if (send_done) begin
            chardata  <= '0;
            isstring  <= 1'b0;
            ispattern <= 1'b0;
            timer     <= '0;
            if (!cur_type) have_str <= 1'b1;
          end else begin
            chardata <= mem[rd_ptr[4:0]];
            rd_ptr   <= rd_ptr + 6'd1;
          end
        end
        S_WAIT: begin
          if (sme_valid) begin
            res_valid   <= 1'b1;
            res_match   <= sme_match;
            res_index   <= sme_match ? sme_index : 5'd0;
            res_timeout <= 1'b0;
          end else if (timer == TIMER_LAST) begin
            res_valid   <= 1'b1;
            res_match   <= 1'b0;
            res_index   <= 5'd0;
            res_timeout <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_RESULT: begin
          if (res_ready) res_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sme_record_feeder.sv
// tb/tb_sme_record_feeder.sv - directed plus randomized checks of sme_record_feeder against a queue-based model
module tb_sme_record_feeder;
  localparam int STR_MAX = 32;
  localparam int PAT_MAX = 8;
  localparam int TIMEOUT = 1024;

  typedef logic [7:0] u8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0, in_type = 1'b0, in_last = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready;
  logic [7:0] chardata;
  logic       isstring, ispattern;
  logic       sme_valid = 1'b0, sme_match = 1'b0;
  logic [4:0] sme_index = '0;
  logic       res_valid, res_match, res_timeout;
  logic       res_ready = 1'b0;
  logic [4:0] res_index;
  logic [1:0] err;

  always #5 clk = ~clk;

  sme_record_feeder #(.STR_MAX(STR_MAX), .PAT_MAX(PAT_MAX), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_type(in_type), .in_last(in_last),
    .chardata(chardata), .isstring(isstring), .ispattern(ispattern),
    .sme_valid(sme_valid), .sme_match(sme_match), .sme_index(sme_index),
    .res_valid(res_valid), .res_ready(res_ready), .res_match(res_match), .res_index(res_index),
    .res_timeout(res_timeout), .err(err)
  );

  int   total = 0;
  int   bad = 0;
  bit   m_have_str = 0;
  logic [1:0] m_err = 2'b00;
  u8    m_str[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void s2q(input string s, output u8 q[$]);
    q = {};
    for (int i = 0; i < s.len(); i++) q.push_back(u8'(s[i]));
  endfunction

  // SME stand-in: first position where the pattern occurs in the string, -1 if absent.
  function automatic int find_pat(input u8 s[$], input u8 p[$]);
    for (int i = 0; i + p.size() <= s.size(); i++) begin
      bit ok = 1;
      for (int j = 0; j < p.size(); j++) if (s[i+j] != p[j]) ok = 0;
      if (ok) return i;
    end
    return -1;
  endfunction

  task automatic push(input bit typ, input u8 rec[$]);
    for (int i = 0; i < rec.size(); i++) begin
      int n = 0;
      in_valid  = 1'b1;
      in_data   = rec[i];
      in_type   = (i == 0) ? typ : ~typ;
      in_last   = (i == rec.size() - 1);
      sme_valid = typ ? 1'b0 : 1'($urandom_range(0, 1));
      while (!in_ready && n < 100) begin @(negedge clk); n++; end
      if (!in_ready) chk("in_ready_wait", in_ready, 1);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    sme_valid = 1'b0;
  endtask

  // delay < 0 means the SME never answers.
  task automatic run_record(input bit typ, input u8 rec[$], input int delay);
    u8  exp[$];
    int lim = typ ? PAT_MAX : STR_MAX;
    int pos;
    bit early;
    for (int i = 0; i < rec.size() && i < lim; i++) exp.push_back(rec[i]);
    if (rec.size() > lim) m_err[0] = 1'b1;
    push(typ, rec);
    if (typ && !m_have_str) begin
      m_err[1] = 1'b1;
      repeat (3) begin
        chk("drop_no_strobe", {isstring, ispattern}, 0);
        chk("drop_ready", in_ready, 1);
        @(negedge clk);
      end
      chk("drop_err", err, m_err);
      return;
    end
    for (int k = 0; k < exp.size(); k++) begin
      chk("strobe", typ ? ispattern : isstring, 1);
      chk("other_strobe", typ ? isstring : ispattern, 0);
      chk("chardata", chardata, exp[k]);
      chk("busy", in_ready, 0);
      @(negedge clk);
    end
    chk("strobe_end", {isstring, ispattern}, 0);
    chk("char_zero", chardata, 0);
    chk("err", err, m_err);
    if (!typ) begin
      m_have_str = 1;
      m_str = exp;
      chk("ready_back", in_ready, 1);
      return;
    end
    chk("wait_ready", in_ready, 0);
    pos = find_pat(m_str, exp);
    if (delay < 0) begin
      early = 0;
      for (int k = 0; k < TIMEOUT; k++) begin
        early |= res_valid;
        @(negedge clk);
      end
      chk("to_early", early, 0);
      chk("to_valid", res_valid, 1);
      chk("to_flag", res_timeout, 1);
      chk("to_match", res_match, 0);
      chk("to_index", res_index, 0);
    end else begin
      repeat (delay) @(negedge clk);
      chk("res_not_yet", res_valid, 0);
      sme_valid = 1'b1;
      sme_match = (pos >= 0);
      sme_index = (pos >= 0) ? 5'(pos) : 5'($urandom_range(1, 31));
      @(negedge clk);
      sme_valid = 1'b0;
      sme_match = 1'($urandom_range(0, 1));
      sme_index = 5'($urandom);
      chk("res_valid", res_valid, 1);
      chk("res_match", res_match, pos >= 0);
      chk("res_index", res_index, (pos >= 0) ? pos : 0);
      chk("res_timeout", res_timeout, 0);
    end
    repeat ($urandom_range(0, 3)) begin
      @(negedge clk);
      chk("res_hold", res_valid, 1);
      chk("res_hold_match", res_match, (delay >= 0) && (pos >= 0));
      chk("res_hold_ready", in_ready, 0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("res_release", res_valid, 0);
    chk("res_ready_back", in_ready, 1);
  endtask

  initial begin
    u8 q[$];
    u8 p[$];
    repeat (2) @(negedge clk);
    chk("rst_char", chardata, 0);
    chk("rst_strobe", {isstring, ispattern}, 0);
    chk("rst_res", {res_valid, res_match, res_index, res_timeout}, 0);
    chk("rst_err", err, 0);
    chk("rst_ready", in_ready, 1);
    reset = 1'b1;
    @(negedge clk);

    s2q("x", q);    run_record(1, q, 0);
    chk("pat_first_err", err, 2'b10);
    s2q("abcd", q); run_record(0, q, 0);
    s2q("bc", q);   run_record(1, q, 2);
    s2q("z", q);    run_record(0, q, 0);
    s2q("zq", q);   run_record(1, q, 0);

    q = {};
    for (int i = 0; i < 40; i++) q.push_back(u8'(97 + (i % 5)));
    run_record(0, q, 0);
    chk("ovf_err", err[0], 1);
    q = {};
    for (int i = 0; i < 10; i++) q.push_back(u8'(98 + (i % 5)));
    run_record(1, q, 0);
    s2q("cd", q);   run_record(1, q, -1);

    for (int it = 0; it < 8; it++) begin
      int sl = $urandom_range(1, 40);
      q = {};
      for (int i = 0; i < sl; i++) q.push_back(u8'($urandom_range(97, 100)));
      run_record(0, q, 0);
      p = {};
      if ($urandom_range(0, 1) == 1) begin
        int pl = $urandom_range(1, (m_str.size() < PAT_MAX) ? m_str.size() : PAT_MAX);
        int st = $urandom_range(0, m_str.size() - pl);
        for (int i = 0; i < pl; i++) p.push_back(m_str[st+i]);
      end else begin
        int pl = $urandom_range(1, 10);
        for (int i = 0; i < pl; i++) p.push_back(u8'($urandom_range(97, 100)));
      end
      run_record(1, p, $urandom_range(0, 15));
    end

    q = {};
    for (int i = 0; i < 10; i++) q.push_back(u8'(65 + i));
    push(0, q);
    repeat (2) @(negedge clk);
    chk("mid_send_active", isstring, 1);
    #2 reset = 1'b0;
    #1;
    chk("rst_async_strobe", isstring, 0);
    chk("rst_async_err", err, 0);
    chk("rst_async_ready", in_ready, 1);
    m_err = 2'b00;
    m_have_str = 0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    s2q("x", q);    run_record(1, q, 0);
    chk("post_rst_err", err, 2'b10);
    s2q("hello", q); run_record(0, q, 0);
    s2q("llo", q);   run_record(1, q, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
